// File: rtl/bp_update_ctrl_pkg.sv
// Shared types and constants for the branch-predictor table sequencing controller.
package bp_update_ctrl_pkg;

    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_ctrl_state_t;

    // Two-bit saturating counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
    localparam logic [1:0] BP_CNT_WEAK_NT = 2'b01;

    typedef struct packed {
        logic [31:0] addr;
        logic        taken;
    } bp_upd_t;

    localparam int BP_UPD_W = $bits(bp_upd_t);

endpackage

// File: rtl/bp_update_ctrl_if.sv
// Signals between the controller, EX resolution, IF lookup and the predictor tables.
interface bp_update_ctrl_if #(
    parameter int S_PC_IDX = 12
);
    logic                clear;
    logic                resolve_valid;
    logic [31:0]         resolve_addr;
    logic                resolve_taken;
    logic                resolve_ready;
    logic                lookup_req;
    logic                lookup_stall;
    logic                upd_valid;
    logic [31:0]         upd_addr;
    logic                upd_br_en;
    logic                init_we;
    logic [S_PC_IDX-1:0] init_idx;
    logic [1:0]          init_data;
    logic                init_busy;

    modport master (
        input  clear, resolve_valid, resolve_addr, resolve_taken, lookup_req,
        output resolve_ready, lookup_stall, upd_valid, upd_addr, upd_br_en,
               init_we, init_idx, init_data, init_busy
    );

    modport slave (
        output clear, resolve_valid, resolve_addr, resolve_taken, lookup_req,
        input  resolve_ready, lookup_stall, upd_valid, upd_addr, upd_br_en,
               init_we, init_idx, init_data, init_busy
    );
endinterface

// File: rtl/bp_update_ctrl_fifo.sv
// Small circular FIFO buffering resolved-branch updates; flush empties it in one cycle.
module bp_update_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 33,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // NOTE: the storage array has no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
endmodule

// File: rtl/bp_update_ctrl.sv
// Table init sequencer plus lookup/update arbiter for the single-ported predictor tables.
module bp_update_ctrl
    import bp_update_ctrl_pkg::*;
#(
    parameter int S_PC_IDX   = 12,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    bp_update_ctrl_if.master bus
);
    localparam int                  CW         = $clog2(DEPTH) + 1;
    localparam int                  SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]       STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [S_PC_IDX-1:0] IDX_MAX    = '1;

    bp_ctrl_state_t      r_state, w_state_nxt;
    logic [S_PC_IDX-1:0] r_init_idx, w_init_idx_nxt;
    logic [SW-1:0]       r_starve, w_starve_nxt;
    logic                w_push, w_pop, w_flush, w_full, w_empty;
    logic [CW-1:0]       w_count;
    bp_upd_t             w_din, w_head;

    assign w_din = '{addr: bus.resolve_addr, taken: bus.resolve_taken};

    bp_update_fifo #(.DEPTH(DEPTH), .WIDTH(BP_UPD_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= BP_INIT;
            r_init_idx <= '0;
            r_starve   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_idx <= w_init_idx_nxt;
            r_starve   <= w_starve_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt       = r_state;
        w_init_idx_nxt    = '0;
        w_starve_nxt      = '0;
        w_push            = 1'b0;
        w_pop             = 1'b0;
        w_flush           = 1'b0;
        bus.init_we       = 1'b0;
        bus.init_busy     = 1'b0;
        bus.lookup_stall  = 1'b0;
        bus.resolve_ready = 1'b0;
        case (r_state)
            BP_INIT: begin
                bus.init_we      = 1'b1;
                bus.init_busy    = 1'b1;
                bus.lookup_stall = 1'b1;
                if (bus.clear) begin
                    w_init_idx_nxt = '0;
                end else if (r_init_idx == IDX_MAX) begin
                    w_state_nxt = BP_RUN;
                end else begin
                    w_init_idx_nxt = r_init_idx + 1'b1;
                end
            end
            BP_RUN: begin
                bus.resolve_ready = !w_full;
                if (bus.clear) begin
                    // Queued updates belong to the old context and are discarded.
                    w_state_nxt = BP_INIT;
                    w_flush     = 1'b1;
                end else begin
                    w_push = bus.resolve_valid && !w_full;
                    if (!w_empty) begin
                        if (bus.lookup_req && (r_starve < STARVE_LIM)) begin
                            w_starve_nxt = r_starve + 1'b1;
                        end else begin
                            w_pop            = 1'b1;
                            bus.lookup_stall = bus.lookup_req;
                        end
                    end
                end
            end
        endcase
    end

    assign bus.upd_valid = w_pop;
    assign bus.upd_addr  = w_head.addr;
    assign bus.upd_br_en = w_head.taken;
    assign bus.init_idx  = r_init_idx;
    assign bus.init_data = BP_CNT_WEAK_NT;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst) w_count <= CW'(DEPTH));
endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl with a queue-based reference model checked every cycle.
module tb_bp_update_ctrl;
    localparam int S_PC_IDX   = 3;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;
    localparam int ROWS       = 1 << S_PC_IDX;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    bp_update_ctrl_if #(.S_PC_IDX(S_PC_IDX)) bus ();

    bp_update_ctrl #(.S_PC_IDX(S_PC_IDX), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [31:0] addr, input logic tk, input logic lk);
        bus.resolve_valid = rv;
        bus.resolve_addr  = addr;
        bus.resolve_taken = tk;
        bus.lookup_req    = lk;
    endtask

    // Reference model: pending updates as a queue, plus mode, init row and starve count.
    typedef struct {
        logic [31:0] addr;
        logic        taken;
    } upd_t;

    upd_t q[$];
    bit   m_init   = 1'b1;
    int   m_idx    = 0;
    int   m_starve = 0;
    bit   u_accept, u_lk_win, u_serve;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_init   = 1'b1;
            m_idx    = 0;
            m_starve = 0;
        end else if (m_init) begin
            if (bus.clear) m_idx = 0;
            else if (m_idx == ROWS - 1) begin
                m_init = 1'b0;
                m_idx  = 0;
            end else m_idx++;
        end else if (bus.clear) begin
            m_init   = 1'b1;
            m_idx    = 0;
            m_starve = 0;
            q.delete();
        end else begin
            u_accept = bus.resolve_valid && (q.size() < DEPTH);
            u_lk_win = (q.size() > 0) && bus.lookup_req && (m_starve < STARVE_MAX);
            u_serve  = (q.size() > 0) && !u_lk_win;
            m_starve = u_lk_win ? m_starve + 1 : 0;
            if (u_serve) void'(q.pop_front());
            if (u_accept) q.push_back('{bus.resolve_addr, bus.resolve_taken});
        end
    end

    bit c_lk_win, e_valid, e_stall, e_ready;

    always @(negedge clk) begin
        c_lk_win = (q.size() > 0) && bus.lookup_req && (m_starve < STARVE_MAX);
        e_valid  = !m_init && !bus.clear && (q.size() > 0) && !c_lk_win;
        e_stall  = m_init || (e_valid && bus.lookup_req);
        e_ready  = !m_init && (q.size() < DEPTH);
        check("m_init_we",    bus.init_we,       m_init);
        check("m_init_busy",  bus.init_busy,     m_init);
        check("m_init_idx",   bus.init_idx,      m_init ? m_idx : 0);
        check("m_upd_valid",  bus.upd_valid,     e_valid);
        check("m_stall",      bus.lookup_stall,  e_stall);
        check("m_ready",      bus.resolve_ready, e_ready);
        if (e_valid) begin
            check("m_upd_addr",  bus.upd_addr,  q[0].addr);
            check("m_upd_br_en", bus.upd_br_en, q[0].taken);
        end
    end

    logic [31:0] addrs [4];
    logic        takens [4];
    int          seen;

    initial begin
        rst       = 1'b0;
        bus.clear = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        addrs  = '{32'h100, 32'h104, 32'h108, 32'h10C};
        takens = '{1'b1, 1'b0, 1'b1, 1'b0};

        // Reset values and the first full init sweep.
        #2;
        check("rst_init_we", bus.init_we, 1);
        check("rst_ready", bus.resolve_ready, 0);
        check("rst_init_data", bus.init_data, 32'h1);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        for (int i = 0; i < ROWS; i++) begin
            check("init_idx_seq", bus.init_idx, i);
            check("init_we_seq", bus.init_we, 1);
            tick();
        end
        check("run_busy", bus.init_busy, 0);
        check("run_ready", bus.resolve_ready, 1);

        // Four updates, no lookups: each drains the cycle after it is written.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, addrs[i], takens[i], 1'b0);
            tick();
            check("drain_valid", bus.upd_valid, 1);
            check("drain_addr", bus.upd_addr, addrs[i]);
            check("drain_br_en", bus.upd_br_en, takens[i]);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        check("drain_empty", bus.upd_valid, 0);

        // Starvation guard: one entry, lookup held high.
        drive(1'b1, 32'h200, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < STARVE_MAX; k++) begin
            check("starve_lk_stall", bus.lookup_stall, 0);
            check("starve_lk_valid", bus.upd_valid, 0);
            tick();
        end
        check("starve_force_valid", bus.upd_valid, 1);
        check("starve_force_stall", bus.lookup_stall, 1);
        check("starve_force_addr", bus.upd_addr, 32'h200);
        bus.lookup_req = 1'b0;
        tick();

        // Fill to full behind lookups, then push into a full queue.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b1);
            tick();
        end
        drive(1'b1, 32'h310, 1'b1, 1'b0);
        #1;
        check("full_ready", bus.resolve_ready, 0);
        check("full_valid", bus.upd_valid, 1);
        check("full_addr", bus.upd_addr, 32'h300);
        tick();
        check("after_full_ready", bus.resolve_ready, 1);
        check("after_full_addr", bus.upd_addr, 32'h304);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("full_seq_2", bus.upd_addr, 32'h308);
        tick();
        check("full_seq_3", bus.upd_addr, 32'h30C);
        tick();
        check("full_seq_4", bus.upd_addr, 32'h310);
        check("full_seq_4_br", bus.upd_br_en, 1);
        tick();
        check("full_seq_empty", bus.upd_valid, 0);

        // clear with three entries queued: they must never issue.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i), 1'b1, 1'b1);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.lookup_req = 1'b0;
        check("clear_busy", bus.init_busy, 1);
        check("clear_idx", bus.init_idx, 0);
        seen = 0;
        for (int i = 0; i < ROWS + 2; i++) begin
            if (bus.upd_valid) seen++;
            tick();
        end
        check("clear_no_upd", seen, 0);
        check("clear_done", bus.init_busy, 0);

        // Asynchronous reset mid-run with entries queued.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", bus.init_busy, 1);
        check("arst_valid", bus.upd_valid, 0);
        check("arst_stall", bus.lookup_stall, 1);
        check("arst_ready", bus.resolve_ready, 0);
        check("arst_idx", bus.init_idx, 0);
        repeat (2) tick();
        rst = 1'b1;
        #1;
        for (int i = 0; i < ROWS; i++) begin
            check("reinit_idx", bus.init_idx, i);
            tick();
        end
        check("reinit_done", bus.init_busy, 0);
        check("reinit_empty", bus.upd_valid, 0);

        // clear during INIT restarts the row counter.
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        repeat (3) tick();
        check("init_mid_idx", bus.init_idx, 3);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("init_restart_idx", bus.init_idx, 0);
        repeat (ROWS - 1) tick();
        check("init_last_idx", bus.init_idx, ROWS - 1);
        check("init_last_busy", bus.init_busy, 1);
        tick();
        check("init_exit_busy", bus.init_busy, 0);
        check("init_exit_idx", bus.init_idx, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bp_update_ctrl.md
# bp_update_ctrl

Sequencing and arbitration controller for the branch-predictor pattern tables (global, local and chooser), which are single-ported. It clears every table row after reset, or on request, by walking an index counter. It buffers resolved-branch updates from EX in a small FIFO and grants the table port to either the IF lookup or one queued update per cycle, with a starvation guard. It sits between the EX branch-resolution logic, the IF predictor lookup and the predictor tables.

## Interface
- S_PC_IDX, 12: table index width (rows = 2**S_PC_IDX).
- DEPTH, 4: update FIFO entries; power of two, ≥2.
- STARVE_MAX, 3: consecutive cycles the FIFO head may lose to lookup before update is forced.
- clk  in  1  clock.
- rst  in  1  one clock; reset is asynchronous and active-low.
- clear  in  1  synchronous request to re-initialise the tables (e.g. context switch).
- resolve_valid  in  1  EX presents a resolved conditional branch.
- resolve_addr  in  32  PC of the resolved branch.
- resolve_taken  in  1  actual branch outcome.
- resolve_ready  out  1  FIFO can accept this cycle.
- lookup_req  in  1  IF wants the table port this cycle.
- lookup_stall  out  1  IF lookup denied this cycle; IF holds its PC.
- upd_valid  out  1  drive the predictor `update`.
- upd_addr  out  32  drive `i_addr_update`.
- upd_br_en  out  1  drive `br_en`.
- init_we  out  1  write the reset state (weakly not-taken) into row init_idx of every table.
- init_idx  out  S_PC_IDX  row being initialised.
- init_busy  out  1  initialisation in progress.

## Operation
- FSM states and transitions:
  - INIT → RUN after row 2**S_PC_IDX-1 is written.
  - RUN → INIT when clear=1.
  - clear while in INIT restarts init_idx at 0.
- INIT behaviour:
  - init_we=1, init_busy=1, lookup_stall=1, resolve_ready=0, upd_valid=0.
  - init_idx increments once per cycle and wraps to 0 on exit.
  - Entering INIT from RUN empties the FIFO (pending updates dropped) and zeroes the starve counter.
- RUN, enqueue: when resolve_valid && resolve_ready, {resolve_addr, resolve_taken} is written at the tail.
- RUN, resolve_ready = !full. Occupancy is counted before the same-cycle dequeue, so no bypass into a full queue.
- RUN, arbitration when the FIFO is non-empty:
  - Lookup wins: lookup_req=1 and starve<STARVE_MAX. Then upd_valid=0, lookup_stall=0, starve+1.
  - Update wins: lookup_req=0, or starve==STARVE_MAX. Then upd_valid=1 and the head is popped at the clock edge. lookup_stall=lookup_req. starve is cleared.
- RUN, FIFO empty: upd_valid=0, lookup_stall=0, starve held at 0.
- upd_addr/upd_br_en always reflect the FIFO head (don't-care when upd_valid=0).
- Occupancy counter width is clog2(DEPTH)+1. Pointers are clog2(DEPTH) bits and wrap naturally.
- Simultaneous enqueue and dequeue: occupancy unchanged, FIFO order preserved.

## Timing
- Asserting rst forces, asynchronously:
  - state INIT, init_idx=0, occupancy=0, starve=0.
  - Outputs: init_we=1, init_busy=1, lookup_stall=1, resolve_ready=0, upd_valid=0.
- Reset release mid-sequence restarts from row 0.
- INIT lasts exactly 2**S_PC_IDX cycles after rst deassertion. The first RUN cycle follows the cycle with init_idx=max.
- Enqueue-to-earliest-update latency is 1 cycle: entry written at edge t, upd_valid possible in cycle t+1.
- resolve_ready, upd_valid and lookup_stall are combinational from registered state plus lookup_req. There is no path from resolve_valid to resolve_ready.
- An update issued in cycle t is visible to a lookup in t+1 (table write-then-read ordering is owned by the tables).

## Structure
- rv32i_types gains `bp_ctrl_state_t` (INIT, RUN) and the predictor counter encoding constant used as the init value.
- Sub-module `bp_update_fifo` (parameterised DEPTH×33-bit FIFO with full/empty/count) is instantiated once.
- FSM, init counter and arbiter stay in the top.

## Test plan
Bench parameters: S_PC_IDX=3, DEPTH=4, STARVE_MAX=3.
- Reset release → init_idx 0..7 on 8 consecutive cycles with init_we=1; cycle 9 shows init_busy=0, resolve_ready=1.
- Push 4 updates (0x100 T, 0x104 N, 0x108 T, 0x10C N) with lookup_req=0 → upd_valid on 4 cycles in order with matching addr/br_en; resolve_ready=0 only while occupancy=4.
- FIFO holds 1 entry, lookup_req held 1 → lookup granted 3 cycles (lookup_stall=0), 4th cycle upd_valid=1, lookup_stall=1.
- Full FIFO, resolve_valid=1 with lookup_req=0 → one entry popped, new entry not accepted that cycle, accepted the next.
- clear with 3 entries queued → next cycle init_busy=1, occupancy 0, queued updates never appear on upd_valid.
- rst asserted during RUN with entries queued → outputs take reset values immediately; after release a full 8-cycle INIT repeats.
